// File: rtl/round_scheduler.sv
// Session sequencer for the Morse game: launches NUM_ROUNDS timed rounds,
// counts each one down in seconds, inserts a result gap and requests logout at the end.
module round_scheduler #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int ROUND_SECONDS = 10,
    parameter int NUM_ROUNDS    = 10,
    parameter int GAP_CYCLES    = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       LoggedIn,
    input  logic       start_btn,
    input  logic       answer_done,
    output logic       game_start,
    output logic       timeout,
    output logic       round_active,
    output logic [3:0] round_num,
    output logic [3:0] secs_left,
    output logic       session_done,
    output logic       logout_req
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICKS_PER_SEC - 1);
    localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_CYCLES - 1);
    localparam logic [3:0]    SECS_INIT    = 4'(ROUND_SECONDS);
    localparam logic [3:0]    ROUND_LAST   = 4'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_ROUND, S_RESULT, S_DONE
    } state_t;

    state_t        r_state, w_next;
    logic [PW-1:0] r_presc, w_presc;
    logic [GW-1:0] r_gap,   w_gap;
    logic [3:0]    r_round, w_round;
    logic [3:0]    r_secs,  w_secs;
    logic          r_gs, r_to, r_ra, r_sd, r_lr;
    logic          w_gs, w_to, w_ra, w_sd, w_lr;
    logic          w_tick, w_expire, w_gap_end, w_start;

    assign w_tick    = (r_presc == '0);
    assign w_expire  = w_tick && (r_secs == 4'd1);
    assign w_gap_end = (r_gap == GAP_LAST);
    assign w_start   = start_btn && LoggedIn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Losing the login overrides every state; an answer beats a coincident expiry.
    always_comb begin
        w_next = r_state;
        if (!LoggedIn) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_start) w_next = S_LAUNCH;
                S_LAUNCH: w_next = S_ROUND;
                S_ROUND:  if (answer_done || w_expire) w_next = S_RESULT;
                S_RESULT: if (w_gap_end) w_next = (r_round == ROUND_LAST) ? S_DONE : S_LAUNCH;
                S_DONE:   if (w_start) w_next = S_LAUNCH;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_gs = (w_next == S_LAUNCH);
        w_ra = (w_next == S_ROUND);
        w_sd = (w_next == S_DONE);
        w_to = (r_state == S_ROUND) && (w_next == S_RESULT) && !answer_done;
        w_lr = (w_next == S_DONE) && (r_state != S_DONE);

        w_round = r_round;
        if (w_next == S_IDLE)
            w_round = 4'd0;
        else if (w_next == S_LAUNCH)
            w_round = (r_state == S_RESULT) ? r_round + 4'd1 : 4'd1;

        w_secs = r_secs;
        if (w_next == S_IDLE)
            w_secs = 4'd0;
        else if (w_next == S_LAUNCH)
            w_secs = SECS_INIT;
        else if (w_to)
            w_secs = 4'd0;
        else if ((r_state == S_ROUND) && (w_next == S_ROUND) && w_tick)
            w_secs = r_secs - 4'd1;

        // Reload on ROUND entry so the first second is a full TICKS_PER_SEC cycles.
        w_presc = '0;
        if (w_next == S_ROUND)
            w_presc = ((r_state == S_ROUND) && !w_tick) ? r_presc - 1'b1 : PRESC_RELOAD;

        w_gap = ((r_state == S_RESULT) && (w_next == S_RESULT)) ? r_gap + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_gap   <= '0;
            r_round <= 4'd0;
            r_secs  <= 4'd0;
            r_gs    <= 1'b0;
            r_to    <= 1'b0;
            r_ra    <= 1'b0;
            r_sd    <= 1'b0;
            r_lr    <= 1'b0;
        end else begin
            r_presc <= w_presc;
            r_gap   <= w_gap;
            r_round <= w_round;
            r_secs  <= w_secs;
            r_gs    <= w_gs;
            r_to    <= w_to;
            r_ra    <= w_ra;
            r_sd    <= w_sd;
            r_lr    <= w_lr;
        end
    end

    assign game_start   = r_gs;
    assign timeout      = r_to;
    assign round_active = r_ra;
    assign round_num    = r_round;
    assign secs_left    = r_secs;
    assign session_done = r_sd;
    assign logout_req   = r_lr;

endmodule
